// File: rtl/logic_op_arbiter_if.sv
// Request/response bundle for the shared logic unit: two requesters in, one
// result channel plus status counters out.
interface logic_op_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  logic              req0_valid;
  logic              req0_ready;
  logic [1:0]        req0_op;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;
  logic              req1_valid;
  logic              req1_ready;
  logic [1:0]        req1_op;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_id;
  logic [DATA_W-1:0] rsp_data;
  logic              busy;
  logic [CNT_W-1:0]  cnt0;
  logic [CNT_W-1:0]  cnt1;

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_data, busy, cnt0, cnt1
  );

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_data, busy, cnt0, cnt1
  );
endinterface

// File: rtl/logic_op_arbiter.sv
// Round-robin arbiter sharing one registered logic/add unit between a host and
// a local requester; single outstanding transaction, accept -> exec -> respond.
module logic_op_arbiter #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic         okClk,
  input  logic         rst_n,
  logic_op_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              ptr_q, ptr_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic [CNT_W-1:0]  cnt0_q, cnt0_d;
  logic [CNT_W-1:0]  cnt1_q, cnt1_d;

  logic [1:0]        op_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic              id_q;

  logic              grant_id;
  logic              rdy0;
  logic              rdy1;
  logic              accept;

  function automatic logic [DATA_W-1:0] alu_f(input logic [1:0]        op,
                                              input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] r;
    case (op)
      2'b00:   r = a | b;
      2'b01:   r = a & b;
      2'b10:   r = a ^ b;
      default: r = a + b;
    endcase
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] cnt_inc_f(input logic [CNT_W-1:0] c);
    return c + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // Pointer only matters on contention; a lone requester always wins.
  always_comb begin
    grant_id = bus.req1_valid;
    if (bus.req0_valid && bus.req1_valid) begin
      grant_id = ptr_q;
    end
  end

  // Readies are gated by rst_n so nothing transfers while reset is held.
  assign rdy0   = rst_n && (state_q == IDLE) && bus.req0_valid && !grant_id;
  assign rdy1   = rst_n && (state_q == IDLE) && bus.req1_valid &&  grant_id;
  assign accept = rdy0 | rdy1;

  assign bus.req0_ready = rdy0;
  assign bus.req1_ready = rdy1;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.cnt0       = cnt0_q;
  assign bus.cnt1       = cnt1_q;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    cnt0_d      = cnt0_q;
    cnt1_d      = cnt1_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          ptr_d   = ~grant_id;
          state_d = EXEC;
        end
      end
      EXEC: begin
        rsp_data_d  = alu_f(op_q, a_q, b_q);
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          if (rsp_id_q) begin
            cnt1_d = cnt_inc_f(cnt1_q);
          end else begin
            cnt0_d = cnt_inc_f(cnt0_q);
          end
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge okClk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= '0;
      cnt0_q      <= '0;
      cnt1_q      <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      cnt0_q      <= cnt0_d;
      cnt1_q      <= cnt1_d;
    end
  end

  // Operand capture: only meaningful after an accept, so no reset needed.
  always_ff @(posedge okClk) begin
    if (accept) begin
      op_q <= grant_id ? bus.req1_op : bus.req0_op;
      a_q  <= grant_id ? bus.req1_a  : bus.req0_a;
      b_q  <= grant_id ? bus.req1_b  : bus.req0_b;
      id_q <= grant_id;
    end
  end

endmodule

// File: tb/tb_logic_op_arbiter.sv
// Directed bench for logic_op_arbiter: handshake timing, opcodes, round-robin,
// back-pressure, reset mid-operation and counter wrap (narrow counters).
module tb_logic_op_arbiter;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 8;

  logic okClk = 1'b0;
  logic rst_n;
  always #5 okClk = ~okClk;

  logic_op_arbiter_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus();

  logic_op_arbiter #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .okClk (okClk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge okClk);
    #2;
  endtask

  task automatic set_req(input bit id, input logic [1:0] op,
                         input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    if (id) begin
      bus.req1_op = op; bus.req1_a = a; bus.req1_b = b; bus.req1_valid = 1'b1;
    end else begin
      bus.req0_op = op; bus.req0_a = a; bus.req0_b = b; bus.req0_valid = 1'b1;
    end
  endtask

  // Single request from an otherwise quiet IDLE, rsp_ready held high.
  task automatic run_req(input string tag, input bit id, input logic [1:0] op,
                         input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                         input logic [DATA_W-1:0] exp);
    set_req(id, op, a, b);
    bus.rsp_ready = 1'b1;
    #1;
    chk({tag, "_rdy0"}, bus.req0_ready, !id);
    chk({tag, "_rdy1"}, bus.req1_ready, id);
    tick();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    #1;
    chk({tag, "_exec_busy"}, bus.busy, 1'b1);
    chk({tag, "_exec_vld"}, bus.rsp_valid, 1'b0);
    chk({tag, "_exec_rdy"}, bus.req0_ready | bus.req1_ready, 1'b0);
    tick();
    chk({tag, "_vld"}, bus.rsp_valid, 1'b1);
    chk({tag, "_id"}, bus.rsp_id, id);
    chk({tag, "_data"}, bus.rsp_data, exp);
    tick();
    chk({tag, "_done_vld"}, bus.rsp_valid, 1'b0);
    chk({tag, "_done_busy"}, bus.busy, 1'b0);
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.req0_valid = 1'b1;
    bus.req0_op    = 2'b00;
    bus.req0_a     = '0;
    bus.req0_b     = '0;
    bus.req1_valid = 1'b0;
    bus.req1_op    = 2'b00;
    bus.req1_a     = '0;
    bus.req1_b     = '0;
    bus.rsp_ready  = 1'b0;
    #12;
    chk("rst_vld",  bus.rsp_valid, 1'b0);
    chk("rst_id",   bus.rsp_id, 1'b0);
    chk("rst_data", bus.rsp_data, 32'h0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_cnt0", bus.cnt0, 8'h00);
    chk("rst_cnt1", bus.cnt1, 8'h00);
    chk("rst_rdy0", bus.req0_ready, 1'b0);
    bus.req0_valid = 1'b0;
    @(negedge okClk);
    rst_n = 1'b1;
    tick();

    run_req("or", 1'b0, 2'b00, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF);
    chk("or_cnt0", bus.cnt0, 8'd1);
    run_req("add", 1'b1, 2'b11, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001);
    chk("add_cnt1", bus.cnt1, 8'd1);

    // Both requesters continuously valid: grants alternate starting with req0.
    set_req(1'b0, 2'b01, 32'hFFFF_0000, 32'h0F0F_0F0F);
    set_req(1'b1, 2'b10, 32'hAAAA_AAAA, 32'hFFFF_FFFF);
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("rr_rdy0", bus.req0_ready, k[0] == 1'b0);
      chk("rr_rdy1", bus.req1_ready, k[0] == 1'b1);
      tick();
      chk("rr_exec_rdy", bus.req0_ready | bus.req1_ready, 1'b0);
      chk("rr_exec_vld", bus.rsp_valid, 1'b0);
      tick();
      chk("rr_vld", bus.rsp_valid, 1'b1);
      chk("rr_id", bus.rsp_id, k[0]);
      chk("rr_data", bus.rsp_data, k[0] ? 32'h5555_5555 : 32'h0F0F_0000);
      tick();
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    chk("rr_cnt0", bus.cnt0, 8'd3);
    chk("rr_cnt1", bus.cnt1, 8'd3);

    // Back-pressure: hold rsp_ready low for 10 cycles with both requesters waiting.
    set_req(1'b0, 2'b10, 32'h1234_5678, 32'hFFFF_0000);
    bus.rsp_ready = 1'b0;
    #1;
    chk("stall_rdy0", bus.req0_ready, 1'b1);
    tick();
    bus.req0_valid = 1'b0;
    tick();
    set_req(1'b0, 2'b00, 32'h0, 32'h0);
    set_req(1'b1, 2'b00, 32'h0, 32'h0);
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("stall_vld",  bus.rsp_valid, 1'b1);
      chk("stall_data", bus.rsp_data, 32'hEDCB_5678);
      chk("stall_id",   bus.rsp_id, 1'b0);
      chk("stall_busy", bus.busy, 1'b1);
      chk("stall_rdy",  bus.req0_ready | bus.req1_ready, 1'b0);
      tick();
    end
    bus.rsp_ready = 1'b1;
    #1;
    chk("hs_rdy", bus.req0_ready | bus.req1_ready, 1'b0);
    chk("hs_cnt0_pre", bus.cnt0, 8'd3);
    tick();
    chk("rel_vld",  bus.rsp_valid, 1'b0);
    chk("rel_busy", bus.busy, 1'b0);
    chk("rel_cnt0", bus.cnt0, 8'd4);
    chk("rel_cnt1", bus.cnt1, 8'd3);
    chk("rel_rdy0", bus.req0_ready, 1'b0);
    chk("rel_rdy1", bus.req1_ready, 1'b1);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;

    // Reset while in EXEC discards the transaction.
    set_req(1'b1, 2'b00, 32'h1, 32'h2);
    #1;
    chk("rx_rdy1", bus.req1_ready, 1'b1);
    tick();
    bus.req1_valid = 1'b0;
    #1;
    chk("rx_exec_busy", bus.busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rx_busy", bus.busy, 1'b0);
    chk("rx_vld",  bus.rsp_valid, 1'b0);
    chk("rx_cnt0", bus.cnt0, 8'd0);
    chk("rx_cnt1", bus.cnt1, 8'd0);
    tick();
    @(negedge okClk);
    rst_n = 1'b1;
    tick();
    chk("rx_no_rsp", bus.rsp_valid, 1'b0);
    set_req(1'b0, 2'b11, 32'h8000_0001, 32'h8000_0001);
    set_req(1'b1, 2'b00, 32'h0000_0001, 32'h0000_0002);
    #1;
    chk("rx_win_rdy0", bus.req0_ready, 1'b1);
    chk("rx_win_rdy1", bus.req1_ready, 1'b0);
    tick();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    tick();
    chk("rx_rsp_vld",  bus.rsp_valid, 1'b1);
    chk("rx_rsp_id",   bus.rsp_id, 1'b0);
    chk("rx_rsp_data", bus.rsp_data, 32'h0000_0002);
    tick();
    chk("rx_post_cnt0", bus.cnt0, 8'd1);
    chk("rx_post_cnt1", bus.cnt1, 8'd0);

    // Counter wrap: back-to-back req0 completions every 3 cycles.
    set_req(1'b0, 2'b00, 32'h0, 32'h0);
    repeat (254 * 3) tick();
    chk("wrap_pre", bus.cnt0, 8'hFF);
    repeat (3) tick();
    chk("wrap_cnt0", bus.cnt0, 8'h00);
    chk("wrap_cnt1", bus.cnt1, 8'h00);
    bus.req0_valid = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
